// File: rtl/multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_fsm
//   Sequencing controller for the multicycle ARM-subset datapath. Each
//   instruction is walked through FETCH/DECODE/EXECUTE/MEM/WB states that
//   share a single memory port. Memory states are stretched until MemReady.
//   A bounded wait counter traps a stuck handshake to FAULT, and an
//   unimplemented Op (2'b11) also traps to FAULT. FAULT is left only by reset.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low; forces FETCH immediately
//   Op         in   instr[27:26], sampled in DECODE
//   Funct      in   instr[25:20]; [5]=I (immediate), [0]=S/L
//   MemReady   in   memory handshake done this cycle
//   IRWrite    out  load instruction register (FETCH && MemReady)
//   NextPC     out  PC <= PC+4 (FETCH && MemReady)
//   AdrSrc     out  0=PC, 1=ALUOut as memory address
//   ALUSrcA    out  0=Rn, 1=PC
//   ALUSrcB    out  00=Rm, 01=ExtImm, 10=const 4
//   ResultSrc  out  00=ALUOut, 01=ReadData, 10=ALUResult
//   ALUOp      out  1=ALU decoder uses Funct, 0=ADD
//   RegW       out  raw register write
//   MemW       out  raw memory write, held until MemReady
//   Branch     out  raw branch strobe
//   Fault      out  sticky trap indicator
//   State      out  current state (debug), encoding in the table below
//
// State table
//   code | state  | meaning
//   0    | FETCH  | read instruction at PC, PC+4 computed; waits on MemReady
//   1    | DECODE | register read, PC+8 formed, Op decoded
//   2    | EXECR  | data-processing, register operand
//   3    | EXECI  | data-processing, immediate operand
//   4    | ALUWB  | write ALU result to register file
//   5    | MEMADR | compute load/store address
//   6    | MEMRD  | load access; waits on MemReady
//   7    | MEMWB  | write load data to register file
//   8    | MEMWR  | store access, MemW held; waits on MemReady
//   9    | BRANCH | branch target to PC
//   10   | FAULT  | trap; only reset leaves
//   11-15 unused, decode to FAULT on the next edge
// -----------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       Fault,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXECR  = 4'd2,
    S_EXECI  = 4'd3,
    S_ALUWB  = 4'd4,
    S_MEMADR = 4'd5,
    S_MEMRD  = 4'd6,
    S_MEMWB  = 4'd7,
    S_MEMWR  = 4'd8,
    S_BRANCH = 4'd9,
    S_FAULT  = 4'd10
  } state_e;

  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting;
  logic             timeout_hit;
  logic             unused_funct;

  // Only the I and S/L bits of Funct steer sequencing.
  assign unused_funct = ^Funct[4:1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    waiting     = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                  && !MemReady;
    // A handshake completing in the timeout cycle wins, since waiting needs !MemReady.
    timeout_hit = (TIMEOUT != 0) && waiting && (cnt_q == TO_VAL);

    case (state_q)
      S_FETCH:  if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FAULT;
        endcase
      end
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (MemReady) state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FAULT;
    endcase

    if (timeout_hit) state_d = S_FAULT;

    // Counter restarts on any state change and saturates rather than wrapping.
    if (state_d != state_q)
      cnt_d = '0;
    else if (waiting && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + CNT_W'(1);
    else
      cnt_d = cnt_q;
  end

  always_comb begin
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    Fault     = 1'b0;

    case (state_q)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        // Gated by reset so no strobe leaves the block while reset is held.
        IRWrite   = MemReady && reset;
        NextPC    = MemReady && reset;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_EXECR: begin
        ALUOp = 1'b1;
      end
      S_EXECI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      S_ALUWB: begin
        RegW = 1'b1;
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
      end
      S_MEMRD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
      end
      S_FAULT: begin
        Fault = 1'b1;
      end
      default: ;
    endcase
  end

  assign State = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;

  localparam int TIMEOUT = 15;

  localparam int P_FETCH  = 0;
  localparam int P_DECODE = 1;
  localparam int P_EXECR  = 2;
  localparam int P_EXECI  = 3;
  localparam int P_ALUWB  = 4;
  localparam int P_MEMADR = 5;
  localparam int P_MEMRD  = 6;
  localparam int P_MEMWB  = 7;
  localparam int P_MEMWR  = 8;
  localparam int P_BRANCH = 9;
  localparam int P_FAULT  = 10;

  typedef struct packed {
    logic       irw, npc, adr, srca;
    logic [1:0] srcb, res;
    logic       aluop, regw, memw, br, flt;
    logic [3:0] st;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'd0;
  logic       MemReady = 1'b0;
  logic       IRWrite, NextPC, AdrSrc, ALUSrcA, ALUOp, RegW, MemW, Branch, Fault;
  logic [1:0] ALUSrcB, ResultSrc;
  logic [3:0] State;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: current phase, wait count, queue of phases still to come.
  int m_ph = P_FETCH;
  int m_w  = 0;
  int m_q[$];

  outs_t tr[$];

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp), .RegW(RegW),
    .MemW(MemW), .Branch(Branch), .Fault(Fault), .State(State)
  );

  function automatic outs_t expect_of(int ph, bit mr, bit rst);
    outs_t o;
    o = '0;
    o.st = 4'(ph);
    case (ph)
      P_FETCH:  begin o.srca = 1; o.srcb = 2; o.res = 2; o.irw = mr & rst; o.npc = mr & rst; end
      P_DECODE: begin o.srca = 1; o.srcb = 2; o.res = 2; end
      P_EXECR:  begin o.aluop = 1; end
      P_EXECI:  begin o.srcb = 1; o.aluop = 1; end
      P_ALUWB:  begin o.res = 0; o.regw = 1; end
      P_MEMADR: begin o.srcb = 1; end
      P_MEMRD:  begin o.adr = 1; end
      P_MEMWB:  begin o.res = 1; o.regw = 1; end
      P_MEMWR:  begin o.adr = 1; o.memw = 1; end
      P_BRANCH: begin o.srcb = 1; o.res = 2; o.br = 1; end
      default:  begin o.flt = 1; end
    endcase
    return o;
  endfunction

  function automatic outs_t actual();
    outs_t a;
    a = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, RegW, MemW, Branch, Fault, State};
    return a;
  endfunction

  task automatic model_reset();
    m_ph = P_FETCH;
    m_w  = 0;
    m_q.delete();
  endtask

  task automatic model_advance(logic [1:0] op, logic [5:0] fn);
    int nxt;
    case (m_ph)
      P_FETCH: nxt = P_DECODE;
      P_DECODE: begin
        if (op == 2'b00) begin
          nxt = fn[5] ? P_EXECI : P_EXECR;
          m_q.push_back(P_ALUWB);
        end else if (op == 2'b01) nxt = P_MEMADR;
        else if (op == 2'b10)   nxt = P_BRANCH;
        else                    nxt = P_FAULT;
      end
      P_MEMADR: begin
        if (fn[0]) begin
          nxt = P_MEMRD;
          m_q.push_back(P_MEMWB);
        end else nxt = P_MEMWR;
      end
      default: nxt = (m_q.size() != 0) ? m_q.pop_front() : P_FETCH;
    endcase
    m_ph = nxt;
    m_w  = 0;
  endtask

  task automatic model_clock(bit mr, logic [1:0] op, logic [5:0] fn, bit rst);
    if (!rst) begin
      model_reset();
    end else if (m_ph == P_FAULT) begin
      m_ph = P_FAULT;
    end else if (m_ph == P_FETCH || m_ph == P_MEMRD || m_ph == P_MEMWR) begin
      if (mr) model_advance(op, fn);
      else if (TIMEOUT > 0 && m_w == TIMEOUT) begin
        m_ph = P_FAULT;
        m_w  = 0;
        m_q.delete();
      end else m_w++;
    end else begin
      model_advance(op, fn);
    end
  endtask

  task automatic chk(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock: drive at negedge, compare 1ns later, advance model at posedge.
  task automatic step(bit mr, logic [1:0] op, logic [5:0] fn, bit rst);
    outs_t e, a;
    @(negedge clk);
    MemReady = mr; Op = op; Funct = fn; reset = rst;
    if (!rst) model_reset();
    #1;
    e = expect_of(m_ph, mr, rst);
    a = actual();
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL outs: cycle %0d phase %0d got %h, expected %h", cyc, m_ph, a, e);
    end
    tr.push_back(a);
    @(posedge clk);
    model_clock(mr, op, fn, rst);
    cyc++;
  endtask

  task automatic latency(string name, logic [1:0] op, logic [5:0] fn, int req);
    int n;
    n = 0;
    do begin
      step(1'b1, op, fn, 1'b1);
      n++;
      #1;
    end while (State != 4'd0 && n < 12);
    chk(name, n, req);
  endtask

  int cnt;
  int stall;
  bit mr_r, rst_r;
  logic [1:0] op_r;
  logic [5:0] fn_r;

  initial begin
    // Reset held 3 cycles: no strobes even with MemReady high.
    tr.delete();
    repeat (3) step(1'b1, 2'b00, 6'b101000, 1'b0);
    chk("rst_irwrite", int'(tr[2].irw), 0);
    chk("rst_state", int'(tr[2].st), 0);

    // ADD immediate: FETCH, DECODE, EXECI, ALUWB; RegW only in cycle 4.
    tr.delete();
    repeat (4) step(1'b1, 2'b00, 6'b101000, 1'b1);
    chk("first_irwrite", int'(tr[0].irw), 1);
    chk("first_srcb", int'(tr[0].srcb), 2);
    chk("addi_s2", int'(tr[1].st), P_DECODE);
    chk("addi_s3", int'(tr[2].st), P_EXECI);
    chk("addi_s4", int'(tr[3].st), P_ALUWB);
    chk("addi_regw", int'({tr[0].regw, tr[1].regw, tr[2].regw, tr[3].regw}), 1);
    #1 chk("addi_back_fetch", int'(State), P_FETCH);

    latency("lat_dp", 2'b00, 6'b000000, 4);
    latency("lat_ldr", 2'b01, 6'b000001, 5);
    latency("lat_str", 2'b01, 6'b000000, 4);
    latency("lat_b", 2'b10, 6'b000000, 3);

    // LDR with MemReady low for 3 cycles in MEMRD.
    tr.delete();
    repeat (3) step(1'b1, 2'b01, 6'b000001, 1'b1);
    repeat (3) step(1'b0, 2'b01, 6'b000001, 1'b1);
    step(1'b1, 2'b01, 6'b000001, 1'b1);
    step(1'b1, 2'b01, 6'b000001, 1'b1);
    cnt = 0;
    foreach (tr[i]) if (tr[i].st == 4'd6) cnt++;
    chk("ldr_memrd_cycles", cnt, 4);
    chk("ldr_memwb", int'(tr[7].st), P_MEMWB);
    chk("ldr_resultsrc", int'(tr[7].res), 1);

    // STR with MemReady low for 2 cycles: MemW high for 3 cycles.
    tr.delete();
    repeat (3) step(1'b1, 2'b01, 6'b000000, 1'b1);
    step(1'b0, 2'b01, 6'b000000, 1'b1);
    step(1'b0, 2'b01, 6'b000000, 1'b1);
    step(1'b1, 2'b01, 6'b000000, 1'b1);
    chk("str_memw", int'({tr[2].memw, tr[3].memw, tr[4].memw, tr[5].memw}), 7);
    #1 chk("str_back_fetch", int'(State), P_FETCH);

    // Reset asserted during MEMWR drops MemW before the next edge.
    tr.delete();
    repeat (3) step(1'b1, 2'b01, 6'b000000, 1'b1);
    step(1'b0, 2'b01, 6'b000000, 1'b1);
    step(1'b0, 2'b01, 6'b000000, 1'b0);
    chk("rstmid_memw_before", int'(tr[3].memw), 1);
    chk("rstmid_memw", int'(tr[4].memw), 0);
    chk("rstmid_state", int'(tr[4].st), P_FETCH);

    // Unimplemented Op: FAULT after DECODE, sticky.
    tr.delete();
    repeat (2) step(1'b1, 2'b11, 6'b000000, 1'b1);
    repeat (4) step(1'b1, 2'b00, 6'b000000, 1'b1);
    chk("op11_state", int'(tr[2].st), P_FAULT);
    chk("op11_sticky", int'({tr[2].flt, tr[3].flt, tr[4].flt, tr[5].flt}), 15);
    step(1'b1, 2'b00, 6'b000000, 1'b0);

    // MemReady stuck low in FETCH: FAULT after 16 cycles.
    cnt = 0;
    do begin
      step(1'b0, 2'b00, 6'b000000, 1'b1);
      cnt++;
      #1;
    end while (State != 4'd10 && cnt < 40);
    chk("timeout_cycles", cnt, 16);
    step(1'b1, 2'b00, 6'b000000, 1'b0);

    // Handshake arriving in the timeout cycle completes instead of faulting.
    repeat (15) step(1'b0, 2'b00, 6'b000000, 1'b1);
    step(1'b1, 2'b00, 6'b000000, 1'b1);
    #1 chk("timeout_priority", int'(State), P_DECODE);

    // Randomized traffic against the model.
    stall = 0;
    cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      if (stall == 0 && $urandom_range(0, 99) == 0) stall = $urandom_range(10, 22);
      if (stall > 0) begin
        mr_r = 1'b0;
        stall--;
      end else mr_r = ($urandom_range(0, 3) != 0);
      op_r = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      fn_r = 6'($urandom);
      if (m_ph == P_FAULT) cnt++;
      else cnt = 0;
      rst_r = !(cnt > 3 || $urandom_range(0, 299) == 0);
      if (!rst_r) begin
        cnt = 0;
        stall = 0;
      end
      step(mr_r, op_r, fn_r, rst_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
